// File: rtl/wb_pkg.sv
// Shared writeback-stage constants and the default-width entry record.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [WB_ADDR_W-1:0] NOPRegAddr = '0;
  localparam logic [WB_DATA_W-1:0] ZeroWord   = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] wd;
    logic                 wreg;
    logic [WB_DATA_W-1:0] wdata;
    logic [WB_DATA_W-1:0] hi;
    logic [WB_DATA_W-1:0] lo;
    logic                 whilo;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue_fwd_match.sv
// GPR forwarding lookup over occupied queue entries; the youngest matching entry wins.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic [ADDR_W-1:0] i_wd    [DEPTH],
  input  logic              i_wreg  [DEPTH],
  input  logic [DATA_W-1:0] i_wdata [DEPTH],
  input  logic [PW-1:0]     i_rd_ptr,
  input  logic [CW-1:0]     i_count,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);
  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_rd_ptr + PW'(i);
      if ((CW'(i) < i_count) && (i_wreg[w_idx] == WriteEnable) &&
          (i_wd[w_idx] == i_raddr) && (i_raddr != ADDR_W'(NOPRegAddr))) begin
        o_hit  = 1'b1;
        o_data = i_wdata[w_idx];
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// Ordered writeback buffer between MEM and the regfile/HI-LO write ports.
// Optional GPR forwarding lookup enabled by WB_FWD_EN.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_wd,
  input  logic                     in_wreg,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic [DATA_W-1:0]        in_hi,
  input  logic [DATA_W-1:0]        in_lo,
  input  logic                     in_whilo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        wb_wd,
  output logic                     wb_wreg,
  output logic [DATA_W-1:0]        wb_wdata,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic                     wb_whilo,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_FWD_EN
 ,input  logic [ADDR_W-1:0]        fwd_raddr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_accept, w_store, w_pop;
  entry_t        w_head;

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_accept  = in_valid & in_ready;
  // Bubbles are accepted from MEM but never occupy a slot.
  assign w_store   = w_accept & ((in_wreg == WriteEnable) | (in_whilo == WriteEnable));
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  assign wb_wd    = out_valid ? w_head.wd    : ADDR_W'(NOPRegAddr);
  assign wb_wreg  = out_valid ? w_head.wreg  : WriteDisable;
  assign wb_wdata = out_valid ? w_head.wdata : DATA_W'(ZeroWord);
  assign wb_hi    = out_valid ? w_head.hi    : DATA_W'(ZeroWord);
  assign wb_lo    = out_valid ? w_head.lo    : DATA_W'(ZeroWord);
  assign wb_whilo = out_valid ? w_head.whilo : WriteDisable;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot contents are don't-care until the pointers make them visible.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= {in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo};
  end

`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] w_fwd_wd    [DEPTH];
  logic              w_fwd_wreg  [DEPTH];
  logic [DATA_W-1:0] w_fwd_wdata [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
    assign w_fwd_wd[g]    = r_mem[g].wd;
    assign w_fwd_wreg[g]  = r_mem[g].wreg;
    assign w_fwd_wdata[g] = r_mem[g].wdata;
  end

  wb_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd (
    .i_wd     (w_fwd_wd),
    .i_wreg   (w_fwd_wreg),
    .i_wdata  (w_fwd_wdata),
    .i_rd_ptr (r_rd_ptr),
    .i_count  (r_count),
    .i_raddr  (fwd_raddr),
    .o_hit    (fwd_hit),
    .o_data   (fwd_data)
  );
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus randomized traffic against a queue model.
module tb_wb_queue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_wreg, in_whilo, out_ready;
  logic [AW-1:0] in_wd;
  logic [DW-1:0] in_wdata, in_hi, in_lo;
  logic in_ready, out_valid, wb_wreg, wb_whilo;
  logic [AW-1:0] wb_wd;
  logic [DW-1:0] wb_wdata, wb_hi, wb_lo;
  logic [$clog2(DEPTH):0] count;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_raddr;
  logic fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .count(count)
`ifdef WB_FWD_EN
   ,.fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] wdata, hi, lo;
    logic          whilo;
  } ent_t;

  ent_t q[$];
  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated with the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (rst || flush) q.delete();
    else begin
      bit full, popv, acc;
      full = (q.size() == DEPTH);
      popv = (q.size() != 0) && out_ready;
      acc  = in_valid && !full;
      if (popv) void'(q.pop_front());
      if (acc && (in_wreg || in_whilo))
        q.push_back('{wd:in_wd, wreg:in_wreg, wdata:in_wdata, hi:in_hi, lo:in_lo, whilo:in_whilo});
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      ent_t h;
      h = '{wd:'0, wreg:1'b0, wdata:'0, hi:'0, lo:'0, whilo:1'b0};
      if (q.size() != 0) h = q[0];
      chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("m_in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
      chk("m_count",     64'(count),     64'(q.size()));
      chk("m_wb_wd",     64'(wb_wd),     64'(h.wd));
      chk("m_wb_wreg",   64'(wb_wreg),   64'(h.wreg));
      chk("m_wb_wdata",  64'(wb_wdata),  64'(h.wdata));
      chk("m_wb_hi",     64'(wb_hi),     64'(h.hi));
      chk("m_wb_lo",     64'(wb_lo),     64'(h.lo));
      chk("m_wb_whilo",  64'(wb_whilo),  64'(h.whilo));
`ifdef WB_FWD_EN
      begin
        logic eh; logic [DW-1:0] ed;
        eh = 1'b0; ed = '0;
        for (int i = q.size() - 1; i >= 0; i--)
          if (!eh && q[i].wreg && q[i].wd == fwd_raddr && fwd_raddr != 0) begin
            eh = 1'b1; ed = q[i].wdata;
          end
        chk("m_fwd_hit",  64'(fwd_hit),  64'(eh));
        chk("m_fwd_data", 64'(fwd_data), 64'(ed));
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] wd, input logic wreg,
                       input logic [DW-1:0] d, input logic whilo);
    in_valid = v; in_wd = wd; in_wreg = wreg; in_wdata = d;
    in_hi = d ^ 32'h5A5A_0000; in_lo = d ^ 32'h0000_A5A5; in_whilo = whilo;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
`ifdef WB_FWD_EN
    fwd_raddr = '0;
`endif
    step(); step();
    rst = 1'b0;
    chk_on = 1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_wb_wreg",   64'(wb_wreg),   64'd0);
    chk("rst_wb_whilo",  64'(wb_whilo),  64'd0);
    chk("rst_wb_wdata",  64'(wb_wdata),  64'd0);

    // single write
    out_ready = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 32'h1234, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_wd",    64'(wb_wd),     64'd5);
    chk("single_wdata", 64'(wb_wdata),  64'h1234);
    step();
    chk("single_count", 64'(count), 64'd0);

    // fill and backpressure
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 5'(k), 1'b1, 32'(k * 32'h11), 1'b0);
      chk("fill_in_ready", 64'(in_ready), (k <= 4) ? 64'd1 : 64'd0);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      chk("stall_wd",    64'(wb_wd),    64'd1);
      chk("stall_wdata", 64'(wb_wdata), 64'h11);
      chk("stall_count", 64'(count),    64'd4);
      step();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_wd",    64'(wb_wd),    64'(k));
      chk("drain_wdata", 64'(wb_wdata), 64'(k * 32'h11));
      step();
    end
    chk("drain_empty", 64'(count), 64'd0);

    // bubble drop, then simultaneous push/pop at count=2
    out_ready = 1'b0;
    drive(1'b1, 5'd6, 1'b0, 32'hDEAD, 1'b0);
    step();
    chk("bubble_count", 64'(count), 64'd0);
    drive(1'b1, 5'd8, 1'b1, 32'h80, 1'b0); step();
    drive(1'b1, 5'd9, 1'b0, 32'h90, 1'b1); step();
    chk("pp_pre_count", 64'(count), 64'd2);
    drive(1'b1, 5'd10, 1'b1, 32'hA0, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_count",    64'(count),    64'd2);
    chk("pp_head_wd",  64'(wb_wd),    64'd9);
    chk("pp_head_wreg",64'(wb_wreg),  64'd0);
    chk("pp_head_hilo",64'(wb_whilo), 64'd1);

    // flush with same-cycle push
    drive(1'b1, 5'd11, 1'b1, 32'hB0, 1'b0); step();
    chk("fl_pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 32'hC0, 1'b0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("fl_count", 64'(count),     64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    chk("fl_gone", 64'(out_valid), 64'd0);

`ifdef WB_FWD_EN
    out_ready = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 32'hA, 1'b0); step();
    drive(1'b1, 5'd7, 1'b1, 32'hB, 1'b0); step();
    drive(1'b1, 5'd3, 1'b1, 32'hC, 1'b0); step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    fwd_raddr = 5'd7; #1;
    chk("fwd_hit7",  64'(fwd_hit),  64'd1);
    chk("fwd_data7", 64'(fwd_data), 64'hB);
    fwd_raddr = 5'd0; #1;
    chk("fwd_hit0",  64'(fwd_hit),  64'd0);
    out_ready = 1'b1; step(); step();
    out_ready = 1'b0;
    fwd_raddr = 5'd7; #1;
    chk("fwd_hit_after", 64'(fwd_hit), 64'd0);
    rst = 1'b1; step(); rst = 1'b0;
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 1'($urandom),
            $urandom, 1'($urandom));
`ifdef WB_FWD_EN
      fwd_raddr = 5'($urandom_range(0, 7));
`endif
      step();
    end
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
